// File: rtl/scope_trace_writer.sv
// Write side of the oscilloscope frame buffer: clears the screen, captures one
// frame of 3-bit samples, then renders them as a connected trace on frame start.
module scope_trace_writer #(
    parameter int          H_PIX       = 640,
    parameter int          V_PIX       = 480,
    parameter int          LEVEL_STEP  = 29,
    parameter int          THICK       = 2,
    parameter logic [11:0] TRACE_COLOR = 12'hFF0,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [2:0]  sample_data,
    output logic        sample_ready,
    input  logic        freeze,
    input  logic        frame_start,
    output logic        fb_we,
    output logic [8:0]  fb_row,
    output logic [9:0]  fb_col,
    output logic [11:0] fb_data,
    output logic        busy,
    output logic        redraw_done
);

    localparam int          AW          = $clog2(H_PIX);
    localparam logic [9:0]  COL_LAST    = 10'(H_PIX - 1);
    localparam logic [8:0]  ROW_LAST    = 9'(V_PIX - 1);
    localparam logic [8:0]  TRACE_LAST  = 9'(8 * LEVEL_STEP - 1);
    localparam logic [8:0]  STEP9       = 9'(LEVEL_STEP);
    localparam logic [8:0]  THICK_EXTRA = 9'(THICK - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_CAPTURE,
        S_WAIT_FRAME,
        S_LOAD,
        S_DRAW
    } state_t;

    state_t      r_state, w_state_nx;
    logic [8:0]  r_row, w_row_nx;
    logic [9:0]  r_col, w_col_nx;
    logic [9:0]  r_wr_ptr, w_wr_ptr_nx;
    logic [2:0]  r_cur;
    logic [8:0]  r_lo, r_hi;
    logic [2:0]  r_buf [0:H_PIX-1];

    logic        w_we_nx, w_done_nx, w_store, w_load;
    logic [8:0]  w_fb_row_nx;
    logic [9:0]  w_fb_col_nx;
    logic [11:0] w_fb_data_nx;
    logic [2:0]  w_rd_level, w_prev_level;
    logic [8:0]  w_y_cur, w_y_prev, w_lo, w_hi;

    // Level 7 is the top of the screen, so invert before scaling.
    function automatic logic [8:0] levelToRow(input logic [2:0] level);
        logic [8:0] inv;
        inv = {6'd0, 3'd7 - level};
        return inv * STEP9;
    endfunction

    assign sample_ready = (r_state == S_CAPTURE) && !freeze;
    assign busy         = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_DRAW);
    assign w_store      = sample_valid && sample_ready;

    assign w_rd_level   = r_buf[r_col[AW-1:0]];
    assign w_prev_level = (r_col == '0) ? w_rd_level : r_cur;
    assign w_y_cur      = levelToRow(w_rd_level);
    assign w_y_prev     = levelToRow(w_prev_level);
    assign w_lo         = (w_y_prev < w_y_cur) ? w_y_prev : w_y_cur;
    assign w_hi         = ((w_y_prev > w_y_cur) ? w_y_prev : w_y_cur) + THICK_EXTRA;

    always_comb begin
        w_state_nx   = r_state;
        w_row_nx     = r_row;
        w_col_nx     = r_col;
        w_wr_ptr_nx  = r_wr_ptr;
        w_we_nx      = 1'b0;
        w_fb_row_nx  = fb_row;
        w_fb_col_nx  = fb_col;
        w_fb_data_nx = fb_data;
        w_done_nx    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_we_nx      = 1'b1;
                w_fb_row_nx  = r_row;
                w_fb_col_nx  = r_col;
                w_fb_data_nx = BG_COLOR;
                if (r_col == COL_LAST) begin
                    w_col_nx = '0;
                    if (r_row == ROW_LAST) begin
                        w_row_nx    = '0;
                        w_wr_ptr_nx = '0;
                        w_state_nx  = S_CAPTURE;
                    end else begin
                        w_row_nx = r_row + 9'd1;
                    end
                end else begin
                    w_col_nx = r_col + 10'd1;
                end
            end
            S_CAPTURE: begin
                if (w_store) begin
                    if (r_wr_ptr == COL_LAST) begin
                        w_wr_ptr_nx = '0;
                        w_state_nx  = S_WAIT_FRAME;
                    end else begin
                        w_wr_ptr_nx = r_wr_ptr + 10'd1;
                    end
                end
            end
            S_WAIT_FRAME: begin
                if (frame_start) begin
                    w_col_nx   = '0;
                    w_row_nx   = '0;
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load     = 1'b1;
                w_row_nx   = '0;
                w_state_nx = S_DRAW;
            end
            S_DRAW: begin
                w_we_nx      = 1'b1;
                w_fb_row_nx  = r_row;
                w_fb_col_nx  = r_col;
                w_fb_data_nx = (r_row >= r_lo && r_row <= r_hi) ? TRACE_COLOR : BG_COLOR;
                if (r_row == TRACE_LAST) begin
                    w_row_nx = '0;
                    if (r_col == COL_LAST) begin
                        w_col_nx    = '0;
                        w_wr_ptr_nx = '0;
                        w_done_nx   = 1'b1;
                        w_state_nx  = S_CAPTURE;
                    end else begin
                        w_col_nx   = r_col + 10'd1;
                        w_state_nx = S_LOAD;
                    end
                end else begin
                    w_row_nx = r_row + 9'd1;
                end
            end
            default: w_state_nx = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_row       <= '0;
            r_col       <= '0;
            r_wr_ptr    <= '0;
            r_cur       <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            fb_we       <= 1'b0;
            fb_row      <= '0;
            fb_col      <= '0;
            fb_data     <= '0;
            redraw_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_wr_ptr    <= w_wr_ptr_nx;
            fb_we       <= w_we_nx;
            fb_row      <= w_fb_row_nx;
            fb_col      <= w_fb_col_nx;
            fb_data     <= w_fb_data_nx;
            redraw_done <= w_done_nx;
            if (w_load) begin
                r_cur <= w_rd_level;
                r_lo  <= w_lo;
                r_hi  <= w_hi;
            end
        end
    end

    // Only CAPTURE writes and only LOAD reads, so the ports never collide.
    always_ff @(posedge clk_25MHz) begin
        if (w_store) begin
            r_buf[r_wr_ptr[AW-1:0]] <= sample_data;
        end
    end

endmodule

// File: tb/tb_scope_trace_writer.sv
// Directed bench for scope_trace_writer, built with a narrow 16x240 frame so
// clear and draw passes stay short; trace geometry keeps the full 29-row step.
module tb_scope_trace_writer;

    localparam int          H          = 16;
    localparam int          V          = 240;
    localparam int          STEP       = 29;
    localparam int          TRACE_ROWS = 8 * STEP;
    localparam logic [11:0] TRACE      = 12'hFF0;
    localparam logic [11:0] BG         = 12'h000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [2:0]  sample_data;
    logic        sample_ready;
    logic        freeze;
    logic        frame_start;
    logic        fb_we;
    logic [8:0]  fb_row;
    logic [9:0]  fb_col;
    logic [11:0] fb_data;
    logic        busy;
    logic        redraw_done;

    int checkCount = 0;
    int errorCount = 0;
    int litLo [0:H-1];
    int litHi [0:H-1];
    int litCount [0:H-1];
    int writes, addrBad, otherBad, doneCount, busyCycles, badCols;
    bit hit;

    always #5 clk = ~clk;

    scope_trace_writer #(
        .H_PIX(H), .V_PIX(V), .LEVEL_STEP(STEP), .THICK(2),
        .TRACE_COLOR(TRACE), .BG_COLOR(BG)
    ) dut (
        .clk_25MHz(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .freeze(freeze), .frame_start(frame_start),
        .fb_we(fb_we), .fb_row(fb_row), .fb_col(fb_col), .fb_data(fb_data),
        .busy(busy), .redraw_done(redraw_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] data, input logic frz, input logic fs);
        sample_valid = valid;
        sample_data  = data;
        freeze       = frz;
        frame_start  = fs;
        @(negedge clk);
    endtask

    task automatic waitClear(input string tag);
        int  cnt = 0;
        int  badData = 0;
        int  lastRow = -1;
        int  lastCol = -1;
        bit  seen = 0;
        for (int cyc = 0; cyc < H * V + 200 && !seen; cyc++) begin
            @(negedge clk);
            if (fb_we === 1'b1) begin
                cnt++;
                lastRow = fb_row;
                lastCol = fb_col;
                if (fb_data !== BG) badData++;
            end
            if (sample_ready === 1'b1) seen = 1;
        end
        checkOutput({tag, " ready seen"}, seen, 1);
        checkOutput({tag, " writes"}, cnt, H * V);
        checkOutput({tag, " non-bg data"}, badData, 0);
        checkOutput({tag, " last row"}, lastRow, V - 1);
        checkOutput({tag, " last col"}, lastCol, H - 1);
        checkOutput({tag, " busy in capture"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, " we after clear"}, fb_we, 0);
    endtask

    task automatic collectDraw(input string tag, input int pulseAt);
        int total = H * TRACE_ROWS;
        int tail = 0;
        int exCol, exRow;
        bit pulsed = 0;
        writes = 0; addrBad = 0; otherBad = 0; doneCount = 0; busyCycles = 0;
        for (int c = 0; c < H; c++) begin
            litLo[c] = 999; litHi[c] = -1; litCount[c] = 0;
        end
        for (int cyc = 0; cyc < H * (TRACE_ROWS + 1) + 100 && tail < 6; cyc++) begin
            frame_start = 1'b0;
            if (busy === 1'b1) busyCycles++;
            if (redraw_done === 1'b1) doneCount++;
            if (fb_we === 1'b1) begin
                exCol = writes / TRACE_ROWS;
                exRow = writes % TRACE_ROWS;
                if (fb_row !== exRow[8:0] || fb_col !== exCol[9:0]) addrBad++;
                if (fb_data === TRACE) begin
                    if (exCol < H) begin
                        litCount[exCol]++;
                        if (exRow < litLo[exCol]) litLo[exCol] = exRow;
                        if (exRow > litHi[exCol]) litHi[exCol] = exRow;
                    end
                end else if (fb_data !== BG) begin
                    otherBad++;
                end
                writes++;
            end
            if (writes >= total) tail++;
            if (writes == pulseAt && !pulsed) begin
                frame_start = 1'b1;
                pulsed = 1;
            end
            @(negedge clk);
        end
        checkOutput({tag, " writes"}, writes, total);
        checkOutput({tag, " address order errors"}, addrBad, 0);
        checkOutput({tag, " bad colours"}, otherBad, 0);
        checkOutput({tag, " redraw_done pulses"}, doneCount, 1);
        checkOutput({tag, " busy cycles"}, busyCycles, H * (TRACE_ROWS + 1));
        checkOutput({tag, " ready after draw"}, sample_ready, 1);
        checkOutput({tag, " busy after draw"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_data = 3'd0; freeze = 1'b0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset fb_we", fb_we, 0);
        checkOutput("reset fb_row", fb_row, 0);
        checkOutput("reset fb_col", fb_col, 0);
        checkOutput("reset fb_data", fb_data, 0);
        checkOutput("reset sample_ready", sample_ready, 0);
        checkOutput("reset busy", busy, 1);
        checkOutput("reset redraw_done", redraw_done, 0);
        rst = 1'b0;
        waitClear("clear1");

        $display("[TB] capture: flat level 3, frame_start pulsed mid-capture");
        for (int i = 0; i < H; i++) begin
            if (i == H - 1) checkOutput("flat ready before last", sample_ready, 1);
            applyStimulus(1'b1, 3'd3, 1'b0, (i == 5) ? 1'b1 : 1'b0);
            if (i == 5) begin
                checkOutput("frame_start in capture busy", busy, 0);
                checkOutput("frame_start in capture ready", sample_ready, 1);
            end
        end
        checkOutput("flat ready after last", sample_ready, 0);
        repeat (3) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("wait frame ready", sample_ready, 0);
        checkOutput("wait frame busy", busy, 0);
        frame_start = 1'b1;
        @(negedge clk);
        checkOutput("load busy", busy, 1);
        collectDraw("draw1", -1);
        badCols = 0;
        for (int c = 0; c < H; c++)
            if (litLo[c] != 116 || litHi[c] != 117 || litCount[c] != 2) badCols++;
        checkOutput("draw1 wrong columns", badCols, 0);
        checkOutput("draw1 col0 lo", litLo[0], 116);
        checkOutput("draw1 col0 hi", litHi[0], 117);

        $display("[TB] capture: alternating 0/7 with freeze after 10 samples");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, (i % 2 == 0) ? 3'd0 : 3'd7, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++)
            applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
        checkOutput("freeze ready", sample_ready, 0);
        for (int i = 10; i < H; i++) begin
            if (i == H - 1) checkOutput("alt ready before last", sample_ready, 1);
            applyStimulus(1'b1, (i % 2 == 0) ? 3'd0 : 3'd7, 1'b0, 1'b0);
        end
        checkOutput("alt ready after last", sample_ready, 0);
        sample_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        collectDraw("draw2", 1000);
        checkOutput("draw2 col0 lo", litLo[0], 203);
        checkOutput("draw2 col0 hi", litHi[0], 204);
        checkOutput("draw2 col0 count", litCount[0], 2);
        checkOutput("draw2 col1 lo", litLo[1], 0);
        checkOutput("draw2 col1 hi", litHi[1], 204);
        checkOutput("draw2 col2 lo", litLo[2], 0);
        checkOutput("draw2 col2 hi", litHi[2], 204);
        checkOutput("draw2 col2 count", litCount[2], 205);
        checkOutput("draw2 last col hi", litHi[H-1], 204);

        $display("[TB] reset during draw at column 10");
        for (int i = 0; i < H; i++)
            applyStimulus(1'b1, 3'(i % 8), 1'b0, 1'b0);
        sample_valid = 1'b0;
        frame_start = 1'b1;
        hit = 0;
        for (int cyc = 0; cyc < H * (TRACE_ROWS + 1) + 100 && !hit; cyc++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (fb_we === 1'b1 && fb_col === 10'd10) hit = 1;
        end
        checkOutput("reached column 10", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort fb_we", fb_we, 0);
        checkOutput("abort busy", busy, 1);
        checkOutput("abort redraw_done", redraw_done, 0);
        checkOutput("abort sample_ready", sample_ready, 0);
        rst = 1'b0;
        waitClear("clear2");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
